// File: rtl/rob_pkg.sv
// Reorder-buffer shared types and sizes; no logic, no latency.
// Tags are entry index + 1 so tag 0 can mean "no producer".
package rob_pkg;
    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int REG_W    = 5;
    localparam int IDX_W    = $clog2(ROB_SIZE);

    localparam logic [TAG_W-1:0] EMPTY_TAG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic              is_branch;
        logic              pred_taken;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
        logic              jump;
        logic [ADDR_W-1:0] target;
    } rob_entry_t;

    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(idx) + TAG_W'(1);
    endfunction
endpackage

// File: rtl/rob_if.sv
// Decoder/execute/commit bundle around the reorder buffer; slave is the rob side.
// No flow control beyond if_idle; all outputs are qualified by rdy downstream.
interface rob_if;
    import rob_pkg::*;

    logic              rdy;
    logic              if_idle;
    logic [TAG_W-1:0]  alloc_tag;
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_is_branch;
    logic              issue_pred_taken;
    logic [ADDR_W-1:0] issue_pc;
    logic              ex_valid;
    logic [TAG_W-1:0]  ex_tag;
    logic [DATA_W-1:0] ex_data;
    logic              ex_jump;
    logic [ADDR_W-1:0] ex_target;
    logic [TAG_W-1:0]  tag_renew;
    logic [DATA_W-1:0] data_renew;
    logic              commit_valid;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic              clear;
    logic [ADDR_W-1:0] redirect_pc;

    modport slave (
        input  rdy, issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_pc,
               ex_valid, ex_tag, ex_data, ex_jump, ex_target,
        output if_idle, alloc_tag, tag_renew, data_renew, commit_valid, commit_rd,
               commit_data, commit_tag, clear, redirect_pc
    );

    modport master (
        output rdy, issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_pc,
               ex_valid, ex_tag, ex_data, ex_jump, ex_target,
        input  if_idle, alloc_tag, tag_renew, data_renew, commit_valid, commit_rd,
               commit_data, commit_tag, clear, redirect_pc
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: result broadcast 1 cycle after ex_valid, in-order commit 1 cycle after ready.
// Issue refused while full or during clear; rdy low freezes all state and outputs.
module rob
    import rob_pkg::*;
(
    input  logic clk,
    input  logic rst,
    rob_if.slave bus
);
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    rob_entry_t          ent [ROB_SIZE];
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic [IDX_W:0]      count;

    rob_entry_t          head_ent;
    logic [IDX_W-1:0]    res_idx;
    logic                do_issue;
    logic                do_result;
    logic                do_commit;
    logic                mispredict;

    assign bus.if_idle   = (count != (IDX_W+1)'(ROB_SIZE));
    assign bus.alloc_tag = idx_to_tag(tail);

    assign head_ent   = ent[head];
    assign res_idx    = IDX_W'(bus.ex_tag - TAG_W'(1));
    assign do_issue   = bus.issue_valid && bus.if_idle && !bus.clear;
    assign do_result  = bus.ex_valid && (bus.ex_tag != EMPTY_TAG) && !bus.clear;
    assign do_commit  = busy[head] && ready[head];
    assign mispredict = do_commit && head_ent.is_branch && (head_ent.jump != head_ent.pred_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy             <= '0;
            ready            <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            bus.tag_renew    <= EMPTY_TAG;
            bus.data_renew   <= '0;
            bus.commit_valid <= 1'b0;
            bus.commit_rd    <= '0;
            bus.commit_data  <= '0;
            bus.commit_tag   <= EMPTY_TAG;
            bus.clear        <= 1'b0;
            bus.redirect_pc  <= '0;
        end else if (bus.rdy) begin
            bus.commit_valid <= 1'b0;
            bus.clear        <= 1'b0;
            bus.tag_renew    <= EMPTY_TAG;

            if (do_issue) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + 1'b1;
            end

            if (do_result) begin
                ready[res_idx] <= 1'b1;
                bus.tag_renew  <= bus.ex_tag;
                bus.data_renew <= bus.ex_data;
            end

            if (do_commit) begin
                bus.commit_valid <= 1'b1;
                bus.commit_rd    <= head_ent.rd;
                bus.commit_data  <= head_ent.data;
                bus.commit_tag   <= idx_to_tag(head);
                busy[head]       <= 1'b0;
                head             <= head + 1'b1;
            end

            if (do_issue && !do_commit)
                count <= count + 1'b1;
            else if (!do_issue && do_commit)
                count <= count - 1'b1;

            // A wrong-path branch still retires, but everything younger is squashed.
            if (mispredict) begin
                bus.clear       <= 1'b1;
                bus.redirect_pc <= head_ent.jump ? head_ent.target : head_ent.pc + ADDR_W'(4);
                busy            <= '0;
                head            <= '0;
                tail            <= '0;
                count           <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.rdy) begin
            if (do_issue) begin
                ent[tail].rd         <= bus.issue_rd;
                ent[tail].is_branch  <= bus.issue_is_branch;
                ent[tail].pred_taken <= bus.issue_pred_taken;
                ent[tail].pc         <= bus.issue_pc;
            end
            if (do_result) begin
                ent[res_idx].data   <= bus.ex_data;
                ent[res_idx].jump   <= bus.ex_jump;
                ent[res_idx].target <= bus.ex_target;
            end
        end
    end
endmodule

// File: tb/tb_rob.sv
// Reorder-buffer bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against an in-order queue model of the buffer.
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rob_if bus ();

    rob dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        bit          br;
        bit          pred;
        logic [31:0] pc;
        bit          done;
        logic [31:0] data;
        bit          jump;
        logic [31:0] tgt;
    } ment_t;

    ment_t       q[$];
    int          hidx = 0;
    int          total = 0;
    int          bad = 0;
    logic [4:0]  e_tag_renew = '0;
    logic [31:0] e_data_renew = '0;
    bit          e_cv = 0;
    logic [4:0]  e_crd = '0;
    logic [31:0] e_cdata = '0;
    logic [4:0]  e_ctag = '0;
    bit          e_clear = 0;
    logic [31:0] e_rpc = '0;

    function automatic int tag_at(int i);
        return ((hidx + i) % 16) + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit clr, com, mis;
        int sz0;
        ment_t e;
        if (rst) begin
            q.delete(); hidx = 0;
            e_tag_renew = 0; e_data_renew = 0; e_cv = 0; e_crd = 0;
            e_cdata = 0; e_ctag = 0; e_clear = 0; e_rpc = 0;
            return;
        end
        if (!bus.rdy) return;
        clr = e_clear;
        sz0 = q.size();
        com = (sz0 > 0) && q[0].done;
        e_cv = 0; e_clear = 0; e_tag_renew = 0;
        if (bus.issue_valid && sz0 < 16 && !clr) begin
            e = '{rd: bus.issue_rd, br: bus.issue_is_branch, pred: bus.issue_pred_taken,
                  pc: bus.issue_pc, done: 0, data: 0, jump: 0, tgt: 0};
            q.push_back(e);
        end
        if (bus.ex_valid && bus.ex_tag != 0 && !clr) begin
            e_tag_renew = bus.ex_tag;
            e_data_renew = bus.ex_data;
            for (int i = 0; i < sz0; i++)
                if (tag_at(i) == int'(bus.ex_tag)) begin
                    q[i].done = 1; q[i].data = bus.ex_data;
                    q[i].jump = bus.ex_jump; q[i].tgt = bus.ex_target;
                end
        end
        if (com) begin
            e = q.pop_front();
            e_cv = 1; e_crd = e.rd; e_cdata = e.data; e_ctag = 5'(tag_at(0));
            hidx = (hidx + 1) % 16;
            mis = e.br && (e.jump != e.pred);
            if (mis) begin
                e_clear = 1;
                e_rpc = e.jump ? e.tgt : e.pc + 32'd4;
                q.delete(); hidx = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("if_idle", bus.if_idle, q.size() != 16);
        chk("alloc_tag", bus.alloc_tag, 64'(tag_at(q.size())));
        chk("tag_renew", bus.tag_renew, e_tag_renew);
        chk("data_renew", bus.data_renew, e_data_renew);
        chk("commit_valid", bus.commit_valid, e_cv);
        chk("commit_rd", bus.commit_rd, e_crd);
        chk("commit_data", bus.commit_data, e_cdata);
        chk("commit_tag", bus.commit_tag, e_ctag);
        chk("clear", bus.clear, e_clear);
        chk("redirect_pc", bus.redirect_pc, e_rpc);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_is_branch = 0;
        bus.issue_pred_taken = 0; bus.issue_pc = 0;
        bus.ex_valid = 0; bus.ex_tag = 0; bus.ex_data = 0; bus.ex_jump = 0; bus.ex_target = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] pc);
        bus.issue_valid = 1; bus.issue_rd = rd; bus.issue_is_branch = br;
        bus.issue_pred_taken = pred; bus.issue_pc = pc;
        tick();
        idle_in();
    endtask

    task automatic do_ex(input logic [4:0] tag, input logic [31:0] d, input bit j, input logic [31:0] t);
        bus.ex_valid = 1; bus.ex_tag = tag; bus.ex_data = d; bus.ex_jump = j; bus.ex_target = t;
        tick();
        idle_in();
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int cand[$];
        int pick;
        idle_in();
        bus.rdy = 1;

        // Reset state
        do_reset();
        chk("rst_alloc_tag", bus.alloc_tag, 1);
        chk("rst_if_idle", bus.if_idle, 1);
        chk("rst_clear", bus.clear, 0);

        // Three issues, out-of-order completion, in-order commit
        for (int k = 1; k <= 3; k++) begin
            chk("seq_alloc_tag", bus.alloc_tag, k);
            do_issue(5'(k), 0, 0, 32'(4 * k));
            chk("seq_no_commit", bus.commit_valid, 0);
        end
        do_ex(2, 32'h55, 0, 0);
        chk("bcast_tag", bus.tag_renew, 2);
        chk("bcast_data", bus.data_renew, 32'h55);
        tick();
        chk("bcast_once", bus.tag_renew, 0);
        chk("no_early_commit", bus.commit_valid, 0);
        do_ex(1, 32'h11, 0, 0);
        chk("head_result_no_commit", bus.commit_valid, 0);
        tick();
        chk("commit1_tag", bus.commit_tag, 1);
        chk("commit1_data", bus.commit_data, 32'h11);
        tick();
        chk("commit2_valid", bus.commit_valid, 1);
        chk("commit2_tag", bus.commit_tag, 2);
        chk("commit2_rd", bus.commit_rd, 2);

        // Full buffer, refused issue, wrap-around
        do_reset();
        for (int k = 0; k < 16; k++) do_issue(5'(k), 0, 0, 32'(k * 4));
        chk("full_if_idle", bus.if_idle, 0);
        do_issue(5'd31, 0, 0, 32'h999);
        chk("full_refused_tag", bus.alloc_tag, 1);
        do_ex(1, 32'hA1, 0, 0);
        tick();
        chk("full_commit_tag", bus.commit_tag, 1);
        chk("wrap_alloc_tag", bus.alloc_tag, 1);
        do_issue(5'd9, 0, 0, 32'h200);
        chk("wrap_next_tag", bus.alloc_tag, 2);
        do_ex(2, 32'hA2, 0, 0);
        do_issue(5'd10, 0, 0, 32'h204);
        chk("full_commit_refuse_valid", bus.commit_valid, 1);
        chk("full_commit_refuse_tag", bus.alloc_tag, 2);

        // Mispredict: predicted not-taken, actually taken
        do_reset();
        do_issue(1, 1, 0, 32'h20);
        do_issue(2, 0, 0, 32'h24);
        do_ex(1, 32'h24, 1, 32'h100);
        tick();
        chk("mp1_commit", bus.commit_valid, 1);
        chk("mp1_clear", bus.clear, 1);
        chk("mp1_redirect", bus.redirect_pc, 32'h100);
        tick();
        chk("mp1_clear_once", bus.clear, 0);
        chk("mp1_alloc_tag", bus.alloc_tag, 1);

        // Mispredict: predicted taken, actually not taken; stale work during clear
        do_issue(3, 1, 1, 32'h40);
        do_issue(4, 0, 0, 32'h44);
        do_ex(1, 0, 0, 32'h300);
        tick();
        chk("mp2_redirect", bus.redirect_pc, 32'h44);
        bus.ex_valid = 1; bus.ex_tag = 2; bus.ex_data = 32'h99;
        bus.issue_valid = 1; bus.issue_rd = 5;
        tick();
        idle_in();
        chk("stale_no_bcast", bus.tag_renew, 0);
        chk("stale_no_issue", bus.alloc_tag, 1);

        // rdy low freezes a ready head
        do_reset();
        do_issue(7, 0, 0, 32'h80);
        do_ex(1, 32'h77, 0, 0);
        bus.rdy = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rdy_low_no_commit", bus.commit_valid, 0);
            chk("rdy_low_hold_bcast", bus.tag_renew, 1);
        end
        bus.rdy = 1;
        tick();
        chk("rdy_back_commit", bus.commit_valid, 1);
        chk("rdy_back_data", bus.commit_data, 32'h77);

        // Reset wins over a pending commit
        do_issue(8, 0, 0, 32'h90);
        do_ex(2, 32'h88, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_no_commit", bus.commit_valid, 0);
        chk("rst_mid_alloc", bus.alloc_tag, 1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom % 600 == 0);
            bus.rdy = ($urandom % 10 != 0);
            idle_in();
            bus.issue_valid = $urandom % 2;
            bus.issue_rd = 5'($urandom);
            bus.issue_is_branch = ($urandom % 6 == 0);
            bus.issue_pred_taken = $urandom % 2;
            bus.issue_pc = $urandom & 32'hFFFF_FFFC;
            if (e_clear && ($urandom % 2 == 1)) begin
                bus.ex_valid = 1;
                bus.ex_tag = 5'($urandom_range(1, 16));
                bus.ex_data = $urandom;
            end else begin
                cand.delete();
                for (int i = 0; i < q.size(); i++) if (!q[i].done) cand.push_back(i);
                if (cand.size() > 0 && ($urandom % 3 != 0)) begin
                    pick = cand[$urandom % cand.size()];
                    bus.ex_valid = 1;
                    bus.ex_tag = 5'(tag_at(pick));
                    bus.ex_data = $urandom;
                    bus.ex_jump = $urandom % 2;
                    bus.ex_target = $urandom & 32'hFFFF_FFFC;
                end
            end
            tick();
        end
        rst = 0;
        bus.rdy = 1;
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
